melody_sequencer: RTL and testbench



---
 rtl/melody_sequencer.sv | 242 ++++++++++++++++++++++++
 tb/tb_melody_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/melody_sequencer.sv
// melody_sequencer
//   Upstream stage of the music box tone generator. Walks a fixed song ROM
//   (Happy Birthday, one octave) and drives a one-hot note code plus a gate
//   for the tone generator's note selector. Each entry sounds for its
//   programmed number of tempo ticks and is followed by GAP_TICKS silent
//   ticks of articulation gap.
//
// Parameters
//   TICK_DIV  clk cycles per tempo tick (>= 2)
//   GAP_TICKS silent ticks after every entry (0 = no gap)
//   SONG_LEN  number of ROM entries played (1..32)
//
// Ports
//   clk      in   system clock
//   rst      in   asynchronous active-high reset
//   onoff    in   1 = play enabled, 0 = stop and rewind
//   pause    in   1 = freeze position and mute (PLAY/GAP only)
//   restart  in   single-cycle pulse, rewinds to entry 0 and plays
//   note     out  one-hot note: bit0 do .. bit6 si, 0 = silence
//   gate     out  1 while a note is sounding
//   index    out  current ROM entry
//   done     out  song finished
//
// Configuration macro
//   SEQ_LOOP_EN  when defined the song wraps to entry 0 after the last
//                entry and done never asserts.
//
// All outputs are registered: the output process computes the values the
// outputs take after the next edge from the next-state values.

module melody_sequencer #(
  parameter int TICK_DIV  = 1562500,
  parameter int GAP_TICKS = 1,
  parameter int SONG_LEN  = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       onoff,
  input  logic       pause,
  input  logic       restart,
  output logic [6:0] note,
  output logic       gate,
  output logic [4:0] index,
  output logic       done
);

  localparam int TICK_W = $clog2(TICK_DIV);
  localparam int GAP_W  = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(GAP_TICKS);
  localparam logic [4:0]        LAST_IDX  = 5'(SONG_LEN - 1);

  localparam logic [6:0] N_DO  = 7'b0000001;
  localparam logic [6:0] N_RE  = 7'b0000010;
  localparam logic [6:0] N_MI  = 7'b0000100;
  localparam logic [6:0] N_FA  = 7'b0001000;
  localparam logic [6:0] N_SOL = 7'b0010000;
  localparam logic [6:0] N_LA  = 7'b0100000;
  localparam logic [6:0] N_SI  = 7'b1000000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state;
  state_t            state_d;
  logic [TICK_W-1:0] tick_cnt;
  logic [TICK_W-1:0] tick_cnt_d;
  logic [3:0]        dur_cnt;
  logic [3:0]        dur_cnt_d;
  logic [GAP_W-1:0]  gap_cnt;
  logic [GAP_W-1:0]  gap_cnt_d;
  logic [4:0]        index_d;
  logic [6:0]        note_d;
  logic              gate_d;
  logic              done_d;
  logic              advance;
  logic              running;
  logic              tick;
  logic              frozen;

  // Song ROM: {note[6:0], duration[3:0]} in tempo ticks.
  function automatic logic [10:0] song_rom(input logic [4:0] i);
    case (i)
      5'd0:    song_rom = {N_SOL, 4'd3};
      5'd1:    song_rom = {N_SOL, 4'd1};
      5'd2:    song_rom = {N_LA,  4'd4};
      5'd3:    song_rom = {N_SOL, 4'd4};
      5'd4:    song_rom = {N_DO,  4'd4};
      5'd5:    song_rom = {N_SI,  4'd8};
      5'd6:    song_rom = {N_SOL, 4'd3};
      5'd7:    song_rom = {N_SOL, 4'd1};
      5'd8:    song_rom = {N_LA,  4'd4};
      5'd9:    song_rom = {N_SOL, 4'd4};
      5'd10:   song_rom = {N_RE,  4'd4};
      5'd11:   song_rom = {N_DO,  4'd8};
      5'd12:   song_rom = {N_SOL, 4'd3};
      5'd13:   song_rom = {N_SOL, 4'd1};
      5'd14:   song_rom = {N_SOL, 4'd4};
      5'd15:   song_rom = {N_MI,  4'd4};
      5'd16:   song_rom = {N_DO,  4'd4};
      5'd17:   song_rom = {N_SI,  4'd4};
      5'd18:   song_rom = {N_LA,  4'd4};
      5'd19:   song_rom = {N_FA,  4'd3};
      5'd20:   song_rom = {N_FA,  4'd1};
      5'd21:   song_rom = {N_MI,  4'd4};
      5'd22:   song_rom = {N_DO,  4'd4};
      5'd23:   song_rom = {N_RE,  4'd4};
      5'd24:   song_rom = {N_DO,  4'd8};
      default: song_rom = {7'b0,  4'd1};
    endcase
  endfunction

  // A stored duration of 0 still plays for one tick.
  function automatic logic [3:0] rom_dur(input logic [4:0] i);
    logic [10:0] e;
    e = song_rom(i);
    rom_dur = (e[3:0] == 4'd0) ? 4'd1 : e[3:0];
  endfunction

  function automatic logic [6:0] rom_note(input logic [4:0] i);
    logic [10:0] e;
    e = song_rom(i);
    rom_note = e[10:4];
  endfunction

  assign running = (state == PLAY) || (state == GAP);
  assign tick    = running && !pause && (tick_cnt == TICK_LAST);
  // Pause only holds when no higher-priority control moves the FSM.
  assign frozen  = onoff && !restart && pause && running;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tick_cnt <= '0;
      dur_cnt  <= '0;
      gap_cnt  <= '0;
      index    <= '0;
      note     <= '0;
      gate     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_d;
      tick_cnt <= tick_cnt_d;
      dur_cnt  <= dur_cnt_d;
      gap_cnt  <= gap_cnt_d;
      index    <= index_d;
      note     <= note_d;
      gate     <= gate_d;
      done     <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state;
    tick_cnt_d = tick_cnt;
    dur_cnt_d  = dur_cnt;
    gap_cnt_d  = gap_cnt;
    index_d    = index;
    advance    = 1'b0;

    if (!onoff) begin
      state_d    = IDLE;
      tick_cnt_d = '0;
      dur_cnt_d  = '0;
      gap_cnt_d  = '0;
      index_d    = '0;
    end else if (restart || (state == IDLE)) begin
      state_d    = PLAY;
      tick_cnt_d = '0;
      dur_cnt_d  = rom_dur(5'd0);
      gap_cnt_d  = '0;
      index_d    = '0;
    end else begin
      case (state)
        PLAY: begin
          if (!pause) begin
            tick_cnt_d = tick ? '0 : tick_cnt + 1'b1;
            if (tick) begin
              if (dur_cnt > 4'd1) begin
                dur_cnt_d = dur_cnt - 4'd1;
              end else if (GAP_TICKS > 0) begin
                state_d   = GAP;
                gap_cnt_d = GAP_LOAD;
              end else begin
                advance = 1'b1;
              end
            end
          end
        end
        GAP: begin
          if (!pause) begin
            tick_cnt_d = tick ? '0 : tick_cnt + 1'b1;
            if (tick) begin
              if (gap_cnt > GAP_W'(1)) gap_cnt_d = gap_cnt - 1'b1;
              else                     advance   = 1'b1;
            end
          end
        end
        default: ;  // DONE holds until onoff drops or restart
      endcase

      if (advance) begin
        tick_cnt_d = '0;
        if (index < LAST_IDX) begin
          state_d   = PLAY;
          index_d   = index + 5'd1;
          dur_cnt_d = rom_dur(index + 5'd1);
        end else begin
`ifdef SEQ_LOOP_EN
          state_d   = PLAY;
          index_d   = '0;
          dur_cnt_d = rom_dur(5'd0);
`else
          state_d   = DONE;
`endif
        end
      end
    end
  end

  // Output logic: values the registered outputs take after the next edge.
  always_comb begin
    note_d = '0;
    gate_d = 1'b0;
    done_d = 1'b0;
    if ((state_d == PLAY) && !frozen) begin
      note_d = rom_note(index_d);
      gate_d = 1'b1;
    end
    if (state_d == DONE) begin
      done_d = 1'b1;
    end
  end

endmodule

// File: tb/tb_melody_sequencer.sv
// tb_melody_sequencer
//   Bench for melody_sequencer with TICK_DIV=4, GAP_TICKS=1. A timeline
//   model built from the song table gives the expected {note, gate, index,
//   done} frame for every cycle; each driven cycle pushes its expected frame
//   and the frame is popped and compared on the following negedge.

module tb_melody_sequencer;

  localparam int TICK_DIV    = 4;
  localparam int GAP_TICKS   = 1;
  localparam int SONG_LEN    = 25;
  localparam int SONG_CYCLES = 484;
  localparam int FW          = 14;

  localparam logic [6:0] DO  = 7'b0000001;
  localparam logic [6:0] RE  = 7'b0000010;
  localparam logic [6:0] MI  = 7'b0000100;
  localparam logic [6:0] FA  = 7'b0001000;
  localparam logic [6:0] SOL = 7'b0010000;
  localparam logic [6:0] LA  = 7'b0100000;
  localparam logic [6:0] SI  = 7'b1000000;

  logic [6:0] song_note [SONG_LEN] = '{
    SOL, SOL, LA, SOL, DO, SI,
    SOL, SOL, LA, SOL, RE, DO,
    SOL, SOL, SOL, MI, DO, SI, LA,
    FA, FA, MI, DO, RE, DO};
  int song_dur [SONG_LEN] = '{
    3, 1, 4, 4, 4, 8,
    3, 1, 4, 4, 4, 8,
    3, 1, 4, 4, 4, 4, 4,
    3, 1, 4, 4, 4, 8};

  // clock / reset
  logic       clk = 1'b0;
  logic       rst;
  logic       onoff;
  logic       pause;
  logic       restart;
  logic [6:0] note;
  logic       gate;
  logic [4:0] index;
  logic       done;

  always #5 clk = ~clk;

  melody_sequencer #(
    .TICK_DIV (TICK_DIV),
    .GAP_TICKS(GAP_TICKS),
    .SONG_LEN (SONG_LEN)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .onoff  (onoff),
    .pause  (pause),
    .restart(restart),
    .note   (note),
    .gate   (gate),
    .index  (index),
    .done   (done)
  );

  // scoreboard state
  logic [FW-1:0] exp_q[$];
  int            checks = 0;
  int            errors = 0;
  int            t;
  bit            playing;
  string         phase;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got=%h expected=%h", tag, $time, got, exp);
    end
  endtask

  // Expected frame {note, gate, index, done} at active time t_in after the
  // edge that started playback from entry 0.
  function automatic logic [FW-1:0] frame(input int t_in);
    int tt;
    int len;
    tt = t_in;
`ifdef SEQ_LOOP_EN
    tt = t_in % SONG_CYCLES;
`endif
    for (int i = 0; i < SONG_LEN; i++) begin
      len = song_dur[i] * TICK_DIV;
      if (tt < len) return {song_note[i], 1'b1, 5'(i), 1'b0};
      tt -= len;
      if (tt < GAP_TICKS * TICK_DIV) return {7'b0, 1'b0, 5'(i), 1'b0};
      tt -= GAP_TICKS * TICK_DIV;
    end
    return {7'b0, 1'b0, 5'(SONG_LEN - 1), 1'b1};
  endfunction

  function automatic logic [31:0] observed();
    return {18'b0, note, gate, index, done};
  endfunction

  // driver: apply inputs for the next edge, push the expected result, then
  // compare at the following negedge.
  task automatic drive_cycle(input bit on_v, input bit pa_v, input bit rs_v);
    logic [FW-1:0] e;
    logic [FW-1:0] f;
    onoff   = on_v;
    pause   = pa_v;
    restart = rs_v;
    if (!on_v) begin
      playing = 1'b0;
      t       = 0;
      e       = '0;
    end else if (rs_v || !playing) begin
      playing = 1'b1;
      t       = 0;
      e       = frame(0);
    end else begin
      f = frame(t);
      if (pa_v && !f[0]) begin
        e = {7'b0, 1'b0, f[5:1], 1'b0};
      end else begin
        t++;
        e = frame(t);
      end
    end
    exp_q.push_back(e);
    @(negedge clk);
    check(phase, observed(), {18'b0, exp_q.pop_front()});
  endtask

  task automatic run_until_entry(input int n);
    logic [FW-1:0] f;
    int guard;
    guard = 0;
    f = frame(t);
    while ((f[5:1] != 5'(n)) && (guard < 3000)) begin
      drive_cycle(1'b1, 1'b0, 1'b0);
      f = frame(t);
      guard++;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    onoff   = 1'b0;
    pause   = 1'b0;
    restart = 1'b0;
    playing = 1'b0;
    t       = 0;
    repeat (3) @(negedge clk);
    check("reset_state", observed(), 32'd0);
    rst = 1'b0;

    phase = "idle";
    repeat (3) drive_cycle(1'b0, 1'b0, 1'b0);
    // restart with onoff low is ignored
    drive_cycle(1'b0, 1'b0, 1'b1);
    drive_cycle(1'b0, 1'b0, 1'b0);

    // first notes, then a 10-cycle pause in the middle of entry 2 (la)
    phase = "play_start";
    run_until_entry(2);
    repeat (6) drive_cycle(1'b1, 1'b0, 1'b0);
    phase = "pause";
    repeat (10) drive_cycle(1'b1, 1'b1, 1'b0);
    phase = "full_song";
    while (t < SONG_CYCLES + 12) drive_cycle(1'b1, 1'b0, 1'b0);
    phase = "pause_in_done";
    repeat (3) drive_cycle(1'b1, 1'b1, 1'b0);

    phase = "restart_done";
    drive_cycle(1'b1, 1'b0, 1'b1);
    phase = "to_entry7";
    run_until_entry(7);
    drive_cycle(1'b1, 1'b0, 1'b0);
    phase = "onoff_drop";
    repeat (4) drive_cycle(1'b0, 1'b0, 1'b0);
    phase = "reraise";
    run_until_entry(10);
    repeat (5) drive_cycle(1'b1, 1'b0, 1'b0);
    phase = "restart_mid";
    drive_cycle(1'b1, 1'b0, 1'b1);
    phase = "to_entry4";
    run_until_entry(4);
    repeat (3) drive_cycle(1'b1, 1'b0, 1'b0);

    // asynchronous reset between edges
    #2;
    rst = 1'b1;
    #1;
    check("rst_async", observed(), 32'd0);
    playing = 1'b0;
    t       = 0;
    @(negedge clk);
    check("rst_held", observed(), 32'd0);
    rst   = 1'b0;
    phase = "after_rst";
    repeat (30) drive_cycle(1'b1, 1'b0, 1'b0);

    // random control mix
    phase = "random";
    for (int i = 0; i < 400; i++) begin
      drive_cycle(($urandom_range(0, 149) != 0),
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 99) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
